// File: rtl/present_sched_pkg.sv
// present_sched_pkg
//   Shared types, widths and the round-robin pick helper for the PRESENT
//   job scheduler.
//   Contents:
//     BLOCK_W / KEY_W : PRESENT block and key widths (64 / 80)
//     MAX_REQ         : widest requester vector rr_pick can handle
//     state_t         : scheduler FSM states
//     rr_pick()       : one-hot round-robin winner among 'valid' after 'last'
//   Optional feature macro used by the design: PRESENT_SCHED_CYCLE_CNT_EN.
package present_sched_pkg;

    localparam int BLOCK_W   = 64;
    localparam int KEY_W     = 80;
    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CORE_RST,
        RUN,
        RESP
    } state_t;

    // Scan n requesters starting just after 'last', wrapping modulo n; the
    // first valid one found gets the single set bit of the result.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [31:0]        last,
        input logic [31:0]        n
    );
        logic [MAX_REQ-1:0] grant;
        logic [31:0]        idx;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            // last < n and k <= n, so one subtraction is enough to wrap
            idx = last + 32'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (32'(k) <= n) && valid[idx[MAX_IDX_W-1:0]]) begin
                grant[idx[MAX_IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/present_sched_rr_arb.sv
// present_sched_rr_arb
//   Purely combinational N_REQ-way round-robin arbiter.
//   Ports:
//     i_valid [N_REQ]  : pending requests
//     i_last  [IDX_W]  : index of the most recently granted requester
//     o_grant [N_REQ]  : one-hot winner, all-zero when nothing is pending
module present_sched_rr_arb
    import present_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_grant
);

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [MAX_REQ-1:0] w_pick;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_ext
            if (gi < N_REQ) begin : g_req
                assign w_valid_ext[gi] = i_valid[gi];
            end else begin : g_pad
                assign w_valid_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_pick  = rr_pick(w_valid_ext, 32'(i_last), 32'(N_REQ));
    assign o_grant = w_pick[N_REQ-1:0];

    // Padding lanes can never win because their valid bits are tied low.
    generate
        if (N_REQ < MAX_REQ) begin : g_hi
            logic [MAX_REQ-N_REQ-1:0] w_unused_pick_hi;
            assign w_unused_pick_hi = w_pick[MAX_REQ-1:N_REQ];
        end
    endgenerate

endmodule

// File: rtl/present_sched.sv
// present_sched
//   Round-robin scheduler sharing one PRESENT core (64-bit block, 80-bit key)
//   among N_REQ requesters. Each job: IDLE -> LOAD -> CORE_RST -> RUN -> RESP.
//   Ports:
//     clk, rst                    : clock, synchronous active-high reset
//     req_valid_i / req_ready_o   : per-requester handshake (ready one-hot)
//     req_block_i / req_key_i     : packed payloads, slice i = [W*i +: W]
//     req_encdec_i                : 1 = encrypt, 0 = decrypt
//     rsp_valid_o                 : one-cycle done pulse to the owner
//     rsp_block_o / rsp_error_o   : result and timeout flag, held until next RESP
//     rsp_cycles_o                : RUN cycles of last job (macro only)
//     busy_o                      : high whenever the FSM is not IDLE
//     core_rst_o/key/block/encdec : drive the shared core
//     core_block_i / core_end_i   : core result and end flag
//   Macro PRESENT_SCHED_CYCLE_CNT_EN adds the rsp_cycles_o port and counter.
module present_sched
    import present_sched_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*BLOCK_W-1:0] req_block_i,
    input  logic [N_REQ*KEY_W-1:0]   req_key_i,
    input  logic [N_REQ-1:0]         req_encdec_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [BLOCK_W-1:0]       rsp_block_o,
    output logic                     rsp_error_o,
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
    output logic [31:0]              rsp_cycles_o,
`endif
    output logic                     busy_o,
    output logic                     core_rst_o,
    output logic [KEY_W-1:0]         core_key_o,
    output logic [BLOCK_W-1:0]       core_block_o,
    output logic                     core_encdec_o,
    input  logic [BLOCK_W-1:0]       core_block_i,
    input  logic                     core_end_i
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_REQ - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_owner;
    logic [KEY_W-1:0]     r_key;
    logic [BLOCK_W-1:0]   r_block;
    logic                 r_encdec;
    logic [RC_W-1:0]      r_rcnt;
    logic [TO_W-1:0]      r_tcnt;
    logic [N_REQ-1:0]     r_rsp_valid;
    logic [BLOCK_W-1:0]   r_rsp_block;
    logic                 r_rsp_error;
    logic                 r_core_rst;
    logic                 r_busy;
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
    logic [31:0]          r_cyc;
    logic [31:0]          r_rsp_cycles;
`endif

    logic [N_REQ-1:0]     w_grant;
    logic                 w_accept;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [KEY_W-1:0]     w_sel_key;
    logic [BLOCK_W-1:0]   w_sel_block;
    logic                 w_sel_encdec;
    logic [N_REQ-1:0]     w_owner_oh;
    logic [KEY_W-1:0]     w_key_arr   [N_REQ];
    logic [BLOCK_W-1:0]   w_block_arr [N_REQ];

    present_sched_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_valid (req_valid_i),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_key_arr[gi]   = req_key_i[gi*KEY_W +: KEY_W];
            assign w_block_arr[gi] = req_block_i[gi*BLOCK_W +: BLOCK_W];
            assign w_owner_oh[gi]  = (r_owner == IDX_W'(gi));
        end
    endgenerate

    // Grant is already qualified by valid, so any grant bit in IDLE is an accept.
    assign req_ready_o = (r_state == IDLE) ? w_grant : '0;
    assign w_accept    = (r_state == IDLE) && (|w_grant);

    always_comb begin
        w_grant_idx  = '0;
        w_sel_key    = '0;
        w_sel_block  = '0;
        w_sel_encdec = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx  = IDX_W'(i);
                w_sel_key    = w_key_arr[i];
                w_sel_block  = w_block_arr[i];
                w_sel_encdec = req_encdec_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last       <= IDX_MAX;
            r_owner      <= '0;
            r_key        <= '0;
            r_block      <= '0;
            r_encdec     <= 1'b0;
            r_rcnt       <= '0;
            r_tcnt       <= '0;
            r_rsp_valid  <= '0;
            r_rsp_block  <= '0;
            r_rsp_error  <= 1'b0;
            r_core_rst   <= 1'b1;
            r_busy       <= 1'b0;
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
            r_cyc        <= '0;
            r_rsp_cycles <= '0;
`endif
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Latches feed the core buses directly, so they are
                        // already stable during LOAD and stay so until RESP ends.
                        r_key    <= w_sel_key;
                        r_block  <= w_sel_block;
                        r_encdec <= w_sel_encdec;
                        r_owner  <= w_grant_idx;
                        r_last   <= w_grant_idx;
                        r_busy   <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_rcnt  <= '0;
                    r_state <= CORE_RST;
                end
                CORE_RST: begin
                    // core_end_i is deliberately not looked at: it may still
                    // carry the previous job's end flag.
                    if (r_rcnt == RC_LAST) begin
                        r_core_rst <= 1'b0;
                        r_tcnt     <= '0;
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
                        r_cyc      <= '0;
`endif
                        r_state    <= RUN;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                RUN: begin
                    r_tcnt <= r_tcnt + 1'b1;
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
                    if (r_cyc != 32'hFFFF_FFFF) begin
                        r_cyc <= r_cyc + 32'd1;
                    end
`endif
                    // End is tested first so it wins over the last timeout cycle.
                    if (core_end_i || (r_tcnt == TO_LAST)) begin
                        r_rsp_block  <= core_end_i ? core_block_i : '0;
                        r_rsp_error  <= !core_end_i;
                        r_rsp_valid  <= w_owner_oh;
                        r_core_rst   <= 1'b1;
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
                        // Count includes the current (end/timeout) cycle.
                        r_rsp_cycles <= (r_cyc == 32'hFFFF_FFFF) ? r_cyc : r_cyc + 32'd1;
`endif
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_core_rst <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_block_o   = r_rsp_block;
    assign rsp_error_o   = r_rsp_error;
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
    assign rsp_cycles_o  = r_rsp_cycles;
`endif
    assign busy_o        = r_busy;
    assign core_rst_o    = r_core_rst;
    assign core_key_o    = r_key;
    assign core_block_o  = r_block;
    assign core_encdec_o = r_encdec;

endmodule

// File: tb/tb_present_sched.sv
// tb_present_sched
//   Self-checking bench for present_sched with a behavioural PRESENT-80 core
//   model and stub-core modes for timeout and end-flag corner cases.
//   Honours PRESENT_SCHED_CYCLE_CNT_EN to also check rsp_cycles_o.
module tb_present_sched;

    localparam int N_REQ    = 2;
    localparam int RST_CYC  = 2;
    localparam int TO_CYC   = 64;
    localparam int CORE_RUN = 32;
    localparam logic [63:0] STUB_BLK = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [79:0] KEY_F    = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*64-1:0]  req_block;
    logic [N_REQ*80-1:0]  req_key;
    logic [N_REQ-1:0]     req_encdec;
    logic [N_REQ-1:0]     rsp_valid;
    logic [63:0]          rsp_block;
    logic                 rsp_error;
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
    logic [31:0]          rsp_cycles;
`endif
    logic                 busy;
    logic                 core_rst;
    logic [79:0]          core_key;
    logic [63:0]          core_block;
    logic                 core_encdec;
    logic [63:0]          core_out;
    logic                 core_end;

    always #5 clk = ~clk;

    present_sched #(
        .N_REQ          (N_REQ),
        .RST_CYCLES     (RST_CYC),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_block_i   (req_block),
        .req_key_i     (req_key),
        .req_encdec_i  (req_encdec),
        .rsp_valid_o   (rsp_valid),
        .rsp_block_o   (rsp_block),
        .rsp_error_o   (rsp_error),
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
        .rsp_cycles_o  (rsp_cycles),
`endif
        .busy_o        (busy),
        .core_rst_o    (core_rst),
        .core_key_o    (core_key),
        .core_block_o  (core_block),
        .core_encdec_o (core_encdec),
        .core_block_i  (core_out),
        .core_end_i    (core_end)
    );

    // ---------------- PRESENT-80 reference model ----------------
    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] isb(input logic [3:0] x);
        case (x)
            4'h0: return 4'h5; 4'h1: return 4'hE; 4'h2: return 4'hF; 4'h3: return 4'h8;
            4'h4: return 4'hC; 4'h5: return 4'h1; 4'h6: return 4'h2; 4'h7: return 4'hD;
            4'h8: return 4'hB; 4'h9: return 4'h4; 4'hA: return 4'h6; 4'hB: return 4'h3;
            4'hC: return 4'h0; 4'hD: return 4'h7; 4'hE: return 4'h9; default: return 4'hA;
        endcase
    endfunction

    function automatic int ppos(input int i);
        return (i == 63) ? 63 : ((i * 16) % 63);
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[ppos(i)] = s[i];
        return o;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[i] = s[ppos(i)];
        return o;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input int r);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sb(t[79:76]);
        t[19:15] = t[19:15] ^ 5'(r);
        return t;
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int j = 0; j < 16; j++) s[4*j +: 4] = sb(s[4*j +: 4]);
            s = p_layer(s);
            k = key_upd(k, r);
        end
        return s ^ k[79:16];
    endfunction

    function automatic logic [63:0] present_dec(input logic [63:0] ct, input logic [79:0] key);
        logic [63:0] s;
        logic [79:0] k;
        logic [63:0] rk [33];
        k = key;
        rk[0] = '0;
        rk[1] = k[79:16];
        for (int r = 1; r <= 31; r++) begin
            k = key_upd(k, r);
            rk[r+1] = k[79:16];
        end
        s = ct ^ rk[32];
        for (int r = 31; r >= 1; r--) begin
            s = inv_p_layer(s);
            for (int j = 0; j < 16; j++) s[4*j +: 4] = isb(s[4*j +: 4]);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    // ---------------- core model / stubs ----------------
    // mode 0: real PRESENT, end after CORE_RUN RUN cycles
    // mode 1: end never asserted
    // mode 2: end high while in reset and on the last timeout RUN cycle
    int stub_mode;
    int ccnt;

    always @(posedge clk) begin
        if (core_rst) ccnt <= 0;
        else          ccnt <= ccnt + 1;
    end

    always_comb begin
        core_end = 1'b0;
        core_out = '0;
        case (stub_mode)
            0: if (!core_rst && ccnt >= CORE_RUN - 1) begin
                core_end = 1'b1;
                core_out = core_encdec ? present_enc(core_block, core_key)
                                       : present_dec(core_block, core_key);
            end
            2: if (core_rst || ccnt == TO_CYC - 1) begin
                core_end = 1'b1;
                core_out = STUB_BLK;
            end
            default: ;
        endcase
    end

    // ---------------- checking infrastructure ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    typedef struct {
        int          owner;
        logic [63:0] blk;
        logic        err;
        int          lat;
        int          cycles;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Response monitor: pops one expectation per rsp pulse.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with no job outstanding, expected none", rsp_valid);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_owner",   128'(rsp_valid), 128'(2'b01 << mon_e.owner));
                chk("rsp_block",   128'(rsp_block), 128'(mon_e.blk));
                chk("rsp_error",   128'(rsp_error), 128'(mon_e.err));
                chk("rsp_latency", 128'(cyc - mon_e.acc_cyc), 128'(mon_e.lat));
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
                chk("rsp_cycles",  128'(rsp_cycles), 128'(mon_e.cycles));
`endif
            end
        end
    end

    task automatic submit(input int idx, input logic [79:0] key, input logic [63:0] blk,
                          input logic enc, input logic [63:0] exp_blk, input logic exp_err,
                          input int lat, input int cycles, input bit push);
        bit   ok;
        exp_t e;
        @(posedge clk);
        #1;
        req_key[idx*80 +: 80]   = key;
        req_block[idx*64 +: 64] = blk;
        req_encdec[idx]         = enc;
        req_valid[idx]          = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req %0d not granted within 300 cycles, expected grant", idx);
            req_valid[idx] = 1'b0;
        end else begin
            chk("ready_onehot", 128'(req_ready), 128'(2'b01 << idx));
            if (push) begin
                e.owner = idx; e.blk = exp_blk; e.err = exp_err;
                e.lat = lat; e.cycles = cycles; e.acc_cyc = cyc;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            req_valid[idx] = 1'b0;
            @(negedge clk);
            chk("load_core_key",    128'(core_key),    128'(key));
            chk("load_core_block",  128'(core_block),  128'(blk));
            chk("load_core_encdec", 128'(core_encdec), 128'(enc));
            chk("load_core_rst",    128'(core_rst),    128'(1'b1));
            chk("load_busy",        128'(busy),        128'(1'b1));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: %0d responses missing after 400 cycles, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int          idx;
        logic [79:0] key;
        logic [63:0] blk;
        logic        enc;
        logic [63:0] exp_blk;
    } vec_t;

    vec_t vecs [7];
    localparam int LAT_NORM = 2 + RST_CYC + CORE_RUN;
    localparam int LAT_TO   = 2 + RST_CYC + TO_CYC;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int prev_acc;
        exp_t e;

        vecs[0] = '{0, 80'h0,  64'h0,                 1'b1, 64'h5579C1387B228445};
        vecs[1] = '{1, KEY_F,  64'h0,                 1'b1, 64'hE72C46C0F5945049};
        vecs[2] = '{1, KEY_F,  64'hE72C46C0F5945049,  1'b0, 64'h0};
        vecs[3] = '{0, 80'h0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hA112FFC72F68417B};
        vecs[4] = '{1, KEY_F,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h3333DCD3213210D2};
        vecs[5] = '{0, KEY_F,  64'h3333DCD3213210D2,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{1, 80'h0,  64'h5579C1387B228445,  1'b0, 64'h0};

        stub_mode  = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_block  = '0;
        req_key    = '0;
        req_encdec = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_core_rst",    128'(core_rst),    128'(1'b1));
        chk("rst_busy",        128'(busy),        128'(1'b0));
        chk("rst_ready",       128'(req_ready),   128'(2'b00));
        chk("rst_rsp_valid",   128'(rsp_valid),   128'(2'b00));
        chk("rst_rsp_block",   128'(rsp_block),   128'(64'h0));
        chk("rst_rsp_error",   128'(rsp_error),   128'(1'b0));
        chk("rst_core_key",    128'(core_key),    128'(80'h0));
        chk("rst_core_block",  128'(core_block),  128'(64'h0));
        chk("rst_core_encdec", 128'(core_encdec), 128'(1'b0));
`ifdef PRESENT_SCHED_CYCLE_CNT_EN
        chk("rst_rsp_cycles",  128'(rsp_cycles),  128'(32'd0));
`endif

        // Table-driven PRESENT jobs (T1, T2 and extra known-answer vectors)
        for (int v = 0; v < 7; v++) begin
            submit(vecs[v].idx, vecs[v].key, vecs[v].blk, vecs[v].enc,
                   vecs[v].exp_blk, 1'b0, LAT_NORM, CORE_RUN, 1'b1);
            wait_idle();
        end

        // T4: core never ends -> timeout with error, block 0
        stub_mode = 1;
        submit(0, 80'h1234, 64'hDEAD_BEEF, 1'b1, 64'h0, 1'b1, LAT_TO, TO_CYC, 1'b1);
        wait_idle();
        chk("t4_busy_after", 128'(busy), 128'(1'b0));
        stub_mode = 0;

        // T5: reset in the middle of RUN abandons the job silently
        submit(1, KEY_F, 64'h0, 1'b1, 64'h0, 1'b0, 0, 0, 1'b0);
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (!core_rst) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_reached_run", 128'(ok), 128'(1'b1));
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_core_rst",  128'(core_rst),  128'(1'b1));
        chk("t5_busy",      128'(busy),      128'(1'b0));
        chk("t5_rsp_valid", 128'(rsp_valid), 128'(2'b00));
        repeat (60) @(negedge clk);
        submit(0, 80'h0, 64'h0, 1'b1, 64'h5579C1387B228445, 1'b0, LAT_NORM, CORE_RUN, 1'b1);
        wait_idle();

        // T6: stale end during CORE_RST ignored; end on last timeout cycle wins
        stub_mode = 2;
        submit(1, KEY_F, 64'h1, 1'b1, STUB_BLK, 1'b0, LAT_TO, TO_CYC, 1'b1);
        wait_idle();
        stub_mode = 0;

        // T3: both requesters valid from reset -> grants 0,1,0,1 back-to-back
        rst = 1'b1;
        req_key    = {KEY_F, 80'h0};
        req_block  = '0;
        req_encdec = 2'b11;
        req_valid  = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prev_acc = 0;
        for (int g = 0; g < 4; g++) begin
            ok = 1'b0;
            for (int w = 0; w < 200; w++) begin
                @(negedge clk);
                if (req_ready != '0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL t3_grant_timeout: grant %0d not seen, expected grant", g);
            end else begin
                chk("t3_grant", 128'(req_ready), 128'((g % 2 == 0) ? 2'b01 : 2'b10));
                if (g > 0) chk("t3_b2b_gap", 128'(cyc - prev_acc), 128'(LAT_NORM + 1));
                prev_acc  = cyc;
                e.owner   = g % 2;
                e.blk     = (g % 2 == 0) ? 64'h5579C1387B228445 : 64'hE72C46C0F5945049;
                e.err     = 1'b0;
                e.lat     = LAT_NORM;
                e.cycles  = CORE_RUN;
                e.acc_cyc = cyc;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (g == 3) req_valid = '0;
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
